// File: rtl/intt_sdf_top.sv
// 8-point inverse NTT over Z_7681: three radix-2 SDF stages (Gentleman-Sande
// butterflies, depths 1/2/4) followed by an n^-1 scaling multiplier.
// Input is the bit-reversed forward-NTT stream; output is natural order.
module intt_sdf_top #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MODULO     = 7681,
    parameter int unsigned N_INV      = 6721
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] intt_in,
    output logic [DATA_WIDTH-1:0] intt_out,
    output logic                  out_valid,
    output logic                  done_tick,
    output logic                  busy
);

    localparam int unsigned RW   = 13;
    localparam int unsigned TAGS = 10;

    typedef logic [RW-1:0] res_t;

    localparam res_t        Q         = RW'(MODULO);
    localparam res_t        NINV      = RW'(N_INV);
    // floor(2^26 / q) for Barrett reduction of 26-bit products
    localparam logic [13:0] BARRETT_M = 14'((64'd1 << 26) / 64'(MODULO));

    // psi^-k twiddles (valid for q = 7681 only)
    localparam res_t W_M1 = 13'd7098;
    localparam res_t W_M5 = 13'd1728;
    localparam res_t W_M3 = 13'd6832;
    localparam res_t W_M7 = 13'd527;
    localparam res_t W_M2 = 13'd1925;
    localparam res_t W_M6 = 13'd6468;
    localparam res_t W_M4 = 13'd3383;

    function automatic res_t add_mod(input res_t a, input res_t b);
        logic [RW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return RW'(s);
    endfunction

    function automatic res_t sub_mod(input res_t a, input res_t b);
        logic [RW:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) d = d + {1'b0, Q};
        return RW'(d);
    endfunction

    // Barrett estimate is at most one short, so r < 2q before correction
    function automatic res_t mul_mod(input res_t a, input res_t b);
        logic [25:0] p;
        logic [39:0] pm;
        logic [13:0] qe;
        logic [25:0] r;
        p  = 26'(a) * 26'(b);
        pm = 40'(p) * 40'(BARRETT_M);
        qe = 14'(pm >> 26);
        r  = p - 26'(qe) * 26'(Q);
        if (r >= 26'(Q)) r = r - 26'(Q);
        if (r >= 26'(Q)) r = r - 26'(Q);
        return RW'(r);
    endfunction

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        in_valid;
    logic [2:0]  in_idx;
    // {valid, index} of each input sample, delayed to align with later stages
    logic [3:0]  tag_q [TAGS];

    res_t        x_in;
    res_t        dl1_q, dl1_d, s1_q, s1_d, w1;
    res_t        dl2_q [2];
    res_t        dl2_d, s2_q, s2_d, w2;
    logic [2:0]  idx2;
    res_t        dl3_q [4];
    res_t        dl3_d, s3_q, s3_d;
    logic [2:0]  idx3;
    res_t        out_q;
    logic        out_valid_q, done_q;
    logic        unused_in_hi;

    assign x_in         = intt_in[RW-1:0];
    assign unused_in_hi = ^intt_in[DATA_WIDTH-1:RW];

    // Frame counter: accept sample 0 on start when idle or at the frame's last slot
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_valid = 1'b0;
        in_idx   = 3'd0;
        if (state_q == StRun && cnt_q != 3'd7) begin
            in_valid = 1'b1;
            in_idx   = cnt_q + 3'd1;
        end else if (start) begin
            in_valid = 1'b1;
        end
        if (in_valid) begin
            state_d = StRun;
            cnt_d   = in_idx;
        end else begin
            state_d = StIdle;
            cnt_d   = 3'd0;
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StRun) && (cnt_q != 3'd7);

    // Stage 1 (t=1): idle slots carry index 0, so they always flush in fill mode
    always_comb begin
        case (in_idx[2:1])
            2'd0:    w1 = W_M1;
            2'd1:    w1 = W_M5;
            2'd2:    w1 = W_M3;
            default: w1 = W_M7;
        endcase
        if (in_idx[0]) begin
            s1_d  = add_mod(dl1_q, x_in);
            dl1_d = mul_mod(sub_mod(dl1_q, x_in), w1);
        end else begin
            s1_d  = dl1_q;
            dl1_d = x_in;
        end
    end

    // Stage 2 (t=2)
    always_comb begin
        idx2 = tag_q[1][2:0];
        w2   = idx2[2] ? W_M6 : W_M2;
        if (idx2[1]) begin
            s2_d  = add_mod(dl2_q[1], s1_q);
            dl2_d = mul_mod(sub_mod(dl2_q[1], s1_q), w2);
        end else begin
            s2_d  = dl2_q[1];
            dl2_d = s1_q;
        end
    end

    // Stage 3 (t=4)
    always_comb begin
        idx3 = tag_q[4][2:0];
        if (idx3[2]) begin
            s3_d  = add_mod(dl3_q[3], s2_q);
            dl3_d = mul_mod(sub_mod(dl3_q[3], s2_q), W_M4);
        end else begin
            s3_d  = dl3_q[3];
            dl3_d = s2_q;
        end
    end

    // Delay lines, stage registers, scaling and output flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TAGS); i++) tag_q[i] <= 4'd0;
            dl1_q <= '0;
            for (int i = 0; i < 2; i++) dl2_q[i] <= '0;
            for (int i = 0; i < 4; i++) dl3_q[i] <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            tag_q[0] <= {in_valid, in_idx};
            for (int i = 1; i < int'(TAGS); i++) tag_q[i] <= tag_q[i-1];
            dl1_q    <= dl1_d;
            dl2_q[0] <= dl2_d;
            dl2_q[1] <= dl2_q[0];
            dl3_q[0] <= dl3_d;
            for (int i = 1; i < 4; i++) dl3_q[i] <= dl3_q[i-1];
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            out_q       <= mul_mod(s3_q, NINV);
            out_valid_q <= tag_q[TAGS-1][3];
            done_q      <= tag_q[TAGS-1][3] && (tag_q[TAGS-1][2:0] == 3'd7);
        end
    end

    assign intt_out  = {{(DATA_WIDTH-RW){1'b0}}, out_q};
    assign out_valid = out_valid_q;
    assign done_tick = done_q;

endmodule

// File: tb/tb_intt_sdf_top.sv
// Directed and round-trip bench for the 8-point inverse NTT SDF pipeline.
module tb_intt_sdf_top;

    localparam int Q = 7681;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] intt_in;
    logic [63:0] intt_out;
    logic        out_valid;
    logic        done_tick;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pw [16];

    logic [63:0] oq [$];
    int          ocyc [$];
    int          dcyc [$];

    intt_sdf_top #(
        .DATA_WIDTH (64),
        .MODULO     (7681),
        .N_INV      (6721)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .intt_in   (intt_in),
        .intt_out  (intt_out),
        .out_valid (out_valid),
        .done_tick (done_tick),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid output and done pulse with its cycle number
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            oq.push_back(intt_out);
            ocyc.push_back(cyc);
        end
        if (done_tick === 1'b1) dcyc.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int brv(input int p);
        return ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
    endfunction

    // Forward negacyclic NTT coefficient A[k] = sum_j a[j] psi^(j(2k+1))
    function automatic logic [12:0] fwd(input logic [12:0] a [8], input int k);
        longint acc;
        acc = 0;
        for (int j = 0; j < 8; j++)
            acc = (acc + longint'(a[j]) * longint'(pw[(j * (2 * k + 1)) % 16])) % Q;
        return 13'(acc);
    endfunction

    task automatic step(input logic r, input logic s, input logic [63:0] d);
        @(posedge clk);
        #1;
        rst_n   = r;
        start   = s;
        intt_in = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 64'd0);
    endtask

    task automatic clear_mon();
        oq.delete();
        ocyc.delete();
        dcyc.delete();
    endtask

    task automatic drive_frame(input logic [12:0] v [8], output int t0);
        t0 = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, (k == 0), 64'(v[k]));
            if (k == 0) t0 = cyc;
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b1, 64'd5);
        checks++;
        if (intt_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_out: got %0d expected 0", intt_out);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (done_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b expected 0", done_tick);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        idle(2);
    endtask

    task automatic test_const7();
        logic [12:0] e [8];
        int t0;
        e = '{13'd7, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
        clear_mon();
        t0 = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, (k == 0), 64'd7);
            if (k == 0) t0 = cyc;
            checks++;
            if (busy !== (k != 0)) begin
                errors++;
                $display("FAIL const7_busy k=%0d: got %b expected %b", k, busy, (k != 0));
            end
        end
        step(1'b1, 1'b0, 64'd0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL const7_busy_end: got %b expected 0", busy);
        end
        idle(14);
        checks++;
        if (oq.size() != 8) begin
            errors++;
            $display("FAIL const7_count: got %0d expected 8", oq.size());
        end
        for (int j = 0; j < 8 && j < oq.size(); j++) begin
            checks++;
            if (ocyc[j] != t0 + 11 + j) begin
                errors++;
                $display("FAIL const7_time j=%0d: got %0d expected %0d", j, ocyc[j], t0 + 11 + j);
            end
            checks++;
            if (oq[j] !== 64'(e[j])) begin
                errors++;
                $display("FAIL const7_data j=%0d: got %0d expected %0d", j, oq[j], e[j]);
            end
        end
        checks++;
        if (dcyc.size() != 1 || dcyc[0] != t0 + 18) begin
            errors++;
            $display("FAIL const7_done: got %0d pulses first at %0d expected 1 at %0d",
                     dcyc.size(), (dcyc.size() > 0) ? dcyc[0] : -1, t0 + 18);
        end
    endtask

    task automatic test_impulse(input logic with_spurious_start);
        logic [12:0] e [8];
        int t0;
        e = '{13'd6721, 13'd6648, 13'd3121, 13'd854, 13'd1383, 13'd216, 13'd4649, 13'd1026};
        clear_mon();
        t0 = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, (k == 0) || (with_spurious_start && (k == 3 || k == 5)),
                 (k == 0) ? 64'd1 : 64'd0);
            if (k == 0) t0 = cyc;
        end
        idle(14);
        checks++;
        if (oq.size() != 8) begin
            errors++;
            $display("FAIL impulse%0d_count: got %0d expected 8", with_spurious_start, oq.size());
        end
        for (int j = 0; j < 8 && j < oq.size(); j++) begin
            checks++;
            if (ocyc[j] != t0 + 11 + j) begin
                errors++;
                $display("FAIL impulse%0d_time j=%0d: got %0d expected %0d",
                         with_spurious_start, j, ocyc[j], t0 + 11 + j);
            end
            checks++;
            if (oq[j] !== 64'(e[j])) begin
                errors++;
                $display("FAIL impulse%0d_data j=%0d: got %0d expected %0d",
                         with_spurious_start, j, oq[j], e[j]);
            end
        end
        checks++;
        if (dcyc.size() != 1 || dcyc[0] != t0 + 18) begin
            errors++;
            $display("FAIL impulse%0d_done: got %0d pulses expected 1 at %0d",
                     with_spurious_start, dcyc.size(), t0 + 18);
        end
    endtask

    task automatic test_max();
        logic [12:0] v [8];
        int t0;
        for (int k = 0; k < 8; k++) v[k] = 13'd7680;
        clear_mon();
        drive_frame(v, t0);
        idle(14);
        checks++;
        if (oq.size() != 8) begin
            errors++;
            $display("FAIL max_count: got %0d expected 8", oq.size());
        end
        for (int j = 0; j < 8 && j < oq.size(); j++) begin
            checks++;
            if (oq[j] !== ((j == 0) ? 64'd7680 : 64'd0) || ocyc[j] != t0 + 11 + j) begin
                errors++;
                $display("FAIL max_data j=%0d: got %0d at %0d expected %0d at %0d", j, oq[j],
                         ocyc[j], (j == 0) ? 7680 : 0, t0 + 11 + j);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [12:0] v [8];
        logic [12:0] e [8];
        int t0, t1;
        e = '{13'd6721, 13'd6648, 13'd3121, 13'd854, 13'd1383, 13'd216, 13'd4649, 13'd1026};
        for (int k = 0; k < 8; k++) v[k] = 13'd7680;
        clear_mon();
        drive_frame(v, t0);
        step(1'b1, 1'b0, 64'd0);
        step(1'b0, 1'b1, 64'd3);
        idle(2);
        for (int k = 0; k < 8; k++) v[k] = (k == 0) ? 13'd1 : 13'd0;
        drive_frame(v, t1);
        idle(14);
        checks++;
        if (oq.size() != 8) begin
            errors++;
            $display("FAIL rstmid_count: got %0d expected 8", oq.size());
        end
        for (int j = 0; j < 8 && j < oq.size(); j++) begin
            checks++;
            if (ocyc[j] != t0 + 23 + j || oq[j] !== 64'(e[j])) begin
                errors++;
                $display("FAIL rstmid_data j=%0d: got %0d at %0d expected %0d at %0d", j, oq[j],
                         ocyc[j], e[j], t0 + 23 + j);
            end
        end
        checks++;
        if (dcyc.size() != 1 || dcyc[0] != t0 + 30) begin
            errors++;
            $display("FAIL rstmid_done: got %0d pulses expected 1 at %0d", dcyc.size(), t0 + 30);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] a [8];
        logic [12:0] exp_q [$];
        int t0;
        clear_mon();
        t0 = 0;
        for (int f = 0; f < 200; f++) begin
            for (int j = 0; j < 8; j++) begin
                if (f == 0)      a[j] = 13'd7680;
                else if (f == 1) a[j] = 13'd0;
                else             a[j] = 13'($urandom_range(0, 7680));
                exp_q.push_back(a[j]);
            end
            for (int p = 0; p < 8; p++) begin
                // upper bits carry noise that the DUT must ignore
                step(1'b1, (p == 0), {$urandom(), 19'($urandom()), fwd(a, brv(p))});
                if (f == 0 && p == 0) t0 = cyc;
            end
        end
        idle(14);
        checks++;
        if (oq.size() != 1600) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 1600", oq.size());
        end
        for (int i = 0; i < 1600 && i < oq.size(); i++) begin
            checks++;
            if (ocyc[i] != t0 + 11 + i) begin
                errors++;
                $display("FAIL b2b_time i=%0d: got %0d expected %0d", i, ocyc[i], t0 + 11 + i);
            end
            checks++;
            if (oq[i] !== 64'(exp_q[i])) begin
                errors++;
                $display("FAIL b2b_data i=%0d: got %0d expected %0d", i, oq[i], exp_q[i]);
            end
        end
        checks++;
        if (dcyc.size() != 200) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d expected 200", dcyc.size());
        end
        for (int f = 0; f < 200 && f < dcyc.size(); f++) begin
            checks++;
            if (dcyc[f] != t0 + 18 + 8 * f) begin
                errors++;
                $display("FAIL b2b_done f=%0d: got %0d expected %0d", f, dcyc[f], t0 + 18 + 8 * f);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        intt_in = 64'd0;
        pw[0] = 1;
        for (int i = 1; i < 16; i++) pw[i] = int'((longint'(pw[i-1]) * 7154) % Q);
        test_reset();
        test_const7();
        test_impulse(1'b0);
        test_max();
        test_impulse(1'b1);
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
